trigger_in_cond: RTL
====================

// Module: trigger_in_cond
// PURPOSE
//  Trigger front end. Conditions the raw external trigger line: synchronise, glitch filter, edge select.
//  Selects the trigger source: external, software or internal timer.
//  Enforces a minimum spacing between accepted triggers (holdoff).
//  Drives trigger_in of trigger_delay_ctrl with a clean, fixed-width, clk-domain pulse.
// PARAMETERS
//  SYNC_STAGES  2   flops in the ext_trig_in synchroniser (>=2)
//  PULSE_W      4   trigger_out high time in clk cycles (>=1)
//  CNT_W        32  width of the status counters
// PORTS
//  clk              in   1      system clock
//  rst              in   1      reset, synchronous, active-high
//  ext_trig_in      in   1      raw external trigger line, asynchronous to clk
//  soft_trig        in   1      software trigger, 1-cycle pulse, clk domain
//  reg_trig_en      in   1      1 = accept triggers
//  reg_trig_src     in   2      0 ext, 1 soft, 2 internal timer, 3 disabled
//  reg_trig_edge    in   1      external edge select: 0 rising, 1 falling
//  reg_filter_len   in   16     stable cycles required before a level change is accepted
//  reg_holdoff      in   32     minimum cycles from one accept to the next
//  reg_int_period   in   32     internal timer period in cycles; 0 = timer off
//  cnt_clr          in   1      1-cycle pulse that clears both status counters
//  trigger_out      out  1      conditioned trigger pulse, PULSE_W cycles high
//  holdoff_active   out  1      1 while an accepted trigger is in PULSE or HOLDOFF
//  trig_accept_cnt  out  CNT_W  accepted triggers, saturating
//  trig_drop_cnt    out  CNT_W  triggers dropped in PULSE/HOLDOFF, saturating
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, sync chain and filtered level 0, timer 0.
//  Synchroniser: SYNC_STAGES flops on ext_trig_in; output is sync_lvl.
//  Filter:
//   - flt_cnt increments while sync_lvl != flt_lvl; clears when they are equal.
//   - When flt_cnt == reg_filter_len, flt_lvl <= sync_lvl and flt_cnt <= 0.
//   - reg_filter_len = 0: flt_lvl follows sync_lvl with 1 cycle of delay.
//  Edge detection:
//   - ext_evt = 1-cycle pulse on a 0->1 change of flt_lvl (reg_trig_edge = 0) or a 1->0 change (reg_trig_edge = 1).
//   - The first edge after reset is valid, since flt_lvl resets to 0.
//  Internal timer:
//   - tmr counts 0..reg_int_period-1; int_evt fires when tmr == reg_int_period-1.
//   - tmr is held at 0 while reg_trig_en = 0, reg_trig_src != 2, or reg_int_period = 0.
//  Source mux: evt = ext_evt / soft_trig / int_evt per reg_trig_src; src 3 gives evt = 0.
//  Enable gating: evt is ignored (neither counted nor dropped) while reg_trig_en = 0.
//  Effective holdoff: hold_len = max(reg_holdoff, 2*PULSE_W). This guarantees trigger_out low >= PULSE_W between pulses.
//  FSM (IDLE, PULSE, HOLDOFF):
//   - IDLE & evt: go to PULSE; trigger_out <= 1; hold_cnt <= hold_len-1; trig_accept_cnt++.
//   - PULSE: hold_cnt decrements every cycle. After PULSE_W cycles high, trigger_out <= 0 and go to HOLDOFF.
//   - HOLDOFF: hold_cnt decrements; when it reaches 0, go to IDLE.
//   - evt in PULSE or HOLDOFF: trig_drop_cnt++; FSM is unaffected.
//   - holdoff_active = (state != IDLE), registered.
//  Latency:
//   - ext_trig_in edge to trigger_out rise: SYNC_STAGES + reg_filter_len + 2 clk edges.
//   - soft_trig to trigger_out: 1 clk edge.
//  Counters:
//   - Saturate at all-ones.
//   - cnt_clr zeroes both counters. If an increment coincides with cnt_clr, the counter becomes 1.
//  Mid-operation changes:
//   - reg_trig_en falling during PULSE/HOLDOFF: the current pulse and holdoff complete normally.
//   - reg_trig_src change: the timer restarts at 0; the filter and FSM are unaffected.
//   - rst mid-pulse: trigger_out drops on the next clk edge.
//  Register inputs are quasi-static: used directly, not synchronised.
// STRUCTURE
//  Package trig_pkg: SRC_EXT/SRC_SOFT/SRC_TMR/SRC_OFF encodings; FSM state enum (IDLE, PULSE, HOLDOFF).
//  Sub-module trig_glitch_filter (synchroniser + filter + edge select, outputs ext_evt).
//  Top holds the timer, mux, FSM and counters.
// TESTING
//  T1: src=0, edge=0, filter=3, holdoff=100; 1-cycle glitch then a 10-cycle high on ext_trig_in
//      -> no pulse for the glitch; one 4-cycle pulse SYNC_STAGES+5 edges after the high starts; accept_cnt=1.
//  T2: src=0, edge=1; line high 20 cycles then low
//      -> exactly one pulse, on the falling edge only.
//  T3: src=1, holdoff=50; soft_trig at cycles 0, 10, 60
//      -> pulses at 1 and 61; drop_cnt=1; accept_cnt=2.
//  T4: src=2, period=20, holdoff=0
//      -> pulses every 20 cycles; holdoff becomes 8 (2*PULSE_W); no drops.
//  T5: trig_en=0 with 5 events, then cnt_clr coinciding with an accept
//      -> no pulses and counters unchanged while disabled; accept_cnt=1 after the coincident clear.
//  T6: rst asserted during the 2nd cycle of a pulse
//      -> trigger_out=0 and state IDLE next edge; a new event right after rst deasserts is accepted.

Source files
------------

// File: rtl/trig_pkg.sv
// Trigger front end shared definitions.
// Source encodings, FSM states, holdoff helper.
package trig_pkg;

  localparam logic [1:0] SRC_EXT  = 2'd0;
  localparam logic [1:0] SRC_SOFT = 2'd1;
  localparam logic [1:0] SRC_TMR  = 2'd2;
  localparam logic [1:0] SRC_OFF  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_e;

  // Holdoff never shorter than two pulse widths,
  // so the output always stays low >= PULSE_W.
  function automatic logic [31:0] eff_holdoff(
    input logic [31:0] h,
    input logic [31:0] min_len
  );
    return (h > min_len) ? h : min_len;
  endfunction

endpackage

// File: rtl/trig_glitch_filter.sv
// External trigger conditioning:
// synchroniser, stability filter, edge select.
module trig_glitch_filter
  import trig_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_trig_in,
  input  logic        reg_trig_edge,
  input  logic [15:0] reg_filter_len,
  output logic        ext_evt
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_lvl;
  logic                   flt_lvl;
  logic                   flt_d;
  logic [15:0]            flt_cnt;

  assign sync_lvl = sync[SYNC_STAGES-1];

  // Bring the asynchronous line into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ext_trig_in};
    end
  end

  // Accept a level change only after it has been
  // stable for reg_filter_len + 1 samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_lvl <= 1'b0;
      flt_cnt <= '0;
    end else if (sync_lvl == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == reg_filter_len) begin
      flt_lvl <= sync_lvl;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 16'd1;
    end
  end

  // Previous filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_d <= 1'b0;
    end else begin
      flt_d <= flt_lvl;
    end
  end

  assign ext_evt = reg_trig_edge ? (flt_d & ~flt_lvl)
                                 : (flt_lvl & ~flt_d);

endmodule

// File: rtl/trigger_in_cond.sv
// Trigger front end: source select, holdoff FSM,
// fixed-width output pulse and status counters.
module trigger_in_cond
  import trig_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_trig_in,
  input  logic             soft_trig,
  input  logic             reg_trig_en,
  input  logic [1:0]       reg_trig_src,
  input  logic             reg_trig_edge,
  input  logic [15:0]      reg_filter_len,
  input  logic [31:0]      reg_holdoff,
  input  logic [31:0]      reg_int_period,
  input  logic             cnt_clr,
  output logic             trigger_out,
  output logic             holdoff_active,
  output logic [CNT_W-1:0] trig_accept_cnt,
  output logic [CNT_W-1:0] trig_drop_cnt
);

  localparam int PW_W = $clog2(PULSE_W + 1);
  localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_W - 1);
  localparam logic [31:0] MIN_HOLD = 32'(2 * PULSE_W);

  logic             ext_evt;
  logic             int_evt;
  logic             tmr_run;
  logic [31:0]      tmr;
  logic             evt;
  logic             evt_en;
  logic [31:0]      hold_len;
  trig_state_e      state, state_nxt;
  logic [31:0]      hold_cnt, hold_nxt;
  logic [PW_W-1:0]  pw_cnt, pw_nxt;
  logic             trig_nxt;
  logic             accept;
  logic             drop;

  trig_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_flt (
    .clk            (clk),
    .rst            (rst),
    .ext_trig_in    (ext_trig_in),
    .reg_trig_edge  (reg_trig_edge),
    .reg_filter_len (reg_filter_len),
    .ext_evt        (ext_evt)
  );

  assign tmr_run = reg_trig_en
                 & (reg_trig_src == SRC_TMR)
                 & (reg_int_period != 32'd0);
  assign int_evt = tmr_run
                 & (tmr == reg_int_period - 32'd1);

  // Free-running period counter, parked at 0 when unused.
  always_ff @(posedge clk) begin
    if (rst || !tmr_run) begin
      tmr <= '0;
    end else if (int_evt) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 32'd1;
    end
  end

  // Pick the active trigger source.
  always_comb begin
    evt = 1'b0;
    case (reg_trig_src)
      SRC_EXT:  evt = ext_evt;
      SRC_SOFT: evt = soft_trig;
      SRC_TMR:  evt = int_evt;
      SRC_OFF:  evt = 1'b0;
      default:  evt = 1'b0;
    endcase
  end

  assign evt_en   = evt & reg_trig_en;
  assign hold_len = eff_holdoff(reg_holdoff, MIN_HOLD);

  // Next-state logic for pulse generation and holdoff.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    pw_nxt    = pw_cnt;
    trig_nxt  = trigger_out;
    accept    = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (evt_en) begin
          state_nxt = PULSE;
          trig_nxt  = 1'b1;
          hold_nxt  = hold_len - 32'd1;
          pw_nxt    = '0;
          accept    = 1'b1;
        end
      end
      PULSE: begin
        drop     = evt_en;
        hold_nxt = (hold_cnt == 32'd0) ? 32'd0
                                       : hold_cnt - 32'd1;
        pw_nxt   = pw_cnt + 1'b1;
        if (pw_cnt == PW_LAST) begin
          trig_nxt  = 1'b0;
          state_nxt = (hold_cnt <= 32'd1) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        drop     = evt_en;
        hold_nxt = (hold_cnt == 32'd0) ? 32'd0
                                       : hold_cnt - 32'd1;
        if (hold_cnt <= 32'd1) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        trig_nxt  = 1'b0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      pw_cnt         <= '0;
      trigger_out    <= 1'b0;
      holdoff_active <= 1'b0;
    end else begin
      state          <= state_nxt;
      hold_cnt       <= hold_nxt;
      pw_cnt         <= pw_nxt;
      trigger_out    <= trig_nxt;
      holdoff_active <= (state_nxt != IDLE);
    end
  end

  // Saturating accept counter; clear wins but keeps a coincident hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_accept_cnt <= '0;
    end else if (cnt_clr) begin
      trig_accept_cnt <= CNT_W'(accept);
    end else if (accept && (trig_accept_cnt != '1)) begin
      trig_accept_cnt <= trig_accept_cnt + 1'b1;
    end
  end

  // Saturating drop counter with the same clear rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_drop_cnt <= '0;
    end else if (cnt_clr) begin
      trig_drop_cnt <= CNT_W'(drop);
    end else if (drop && (trig_drop_cnt != '1)) begin
      trig_drop_cnt <= trig_drop_cnt + 1'b1;
    end
  end

endmodule
